// File: rtl/mc_control_hs.sv
// rtl/mc_control_hs.sv - multicycle RV32I control FSM with variable-latency memory handshake
// Trap support (TRAP state, bus timeout, misalignment, trap/trap_cause) is enabled by MC_CTRL_TRAP_EN.
module mc_control_hs #(
  parameter int MEM_TIMEOUT = 16,
  parameter int INSTRET_W   = 32
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic [6:0]           opcode,
  input  logic [2:0]           funct3,
  input  logic [6:0]           funct7,
  input  logic                 instr_b20,
  input  logic [4:0]           alu_flags,
  input  logic [1:0]           addr_lo,
  input  logic                 mem_ready,
  output logic                 pc_write,
  output logic                 ir_write,
  output logic                 reg_write,
  output logic                 adr_src,
  output logic                 mem_req,
  output logic                 mem_we,
  output logic [3:0]           mem_be,
  output logic [1:0]           result_src,
  output logic [1:0]           alu_src_a,
  output logic [1:0]           alu_src_b,
  output logic [3:0]           alu_control,
  output logic [2:0]           imm_src,
  output logic                 trap,
  output logic [3:0]           trap_cause,
  output logic [INSTRET_W-1:0] instret
);
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;
  localparam logic [3:0] ALU_ADD = 4'd3;
  localparam logic [3:0] ALU_SUB = 4'd4;
  localparam logic [2:0] IMM_I = 3'd0, IMM_B = 3'd1, IMM_S = 3'd2, IMM_U = 3'd3, IMM_J = 3'd4;

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_EXEC_R, S_EXEC_I, S_ALU_WB, S_MEM_ADDR, S_MEM_READ,
    S_MEM_WB, S_MEM_WRITE, S_BRANCH, S_JAL, S_JALR, S_TRAP
  } state_t;

  state_t state, state_n;
  logic pc_write_c, ir_write_c, reg_write_c, mem_req_c, mem_we_c, trap_c;
  logic [3:0] trap_code, alu_dec, store_be;
  logic taken, is_store, is_link;
  logic [INSTRET_W-1:0] instret_q;

  assign is_store = (opcode == OP_STORE);
  assign is_link  = (opcode == OP_JAL) || (opcode == OP_JALR);
  assign store_be = (funct3[1:0] == 2'b00) ? (4'b0001 << addr_lo) :
                    (funct3[1:0] == 2'b01) ? (addr_lo[1] ? 4'b1100 : 4'b0011) : 4'b1111;

  // SUB is only an R-type encoding; SRA/SRAI share the funct7 marker
  always_comb begin
    alu_dec = ALU_ADD;
    case (funct3)
      3'b000: alu_dec = (opcode == OP_R && funct7 == 7'b0100000) ? ALU_SUB : ALU_ADD;
      3'b001: alu_dec = 4'd7;
      3'b010: alu_dec = 4'd5;
      3'b011: alu_dec = 4'd6;
      3'b100: alu_dec = 4'd2;
      3'b101: alu_dec = (funct7 == 7'b0100000) ? 4'd9 : 4'd8;
      3'b110: alu_dec = 4'd1;
      default: alu_dec = 4'd0;
    endcase
  end

  always_comb begin
    case (funct3)
      3'b000:  taken = alu_flags[4];
      3'b001:  taken = ~alu_flags[4];
      3'b100:  taken = alu_flags[3];
      3'b101:  taken = ~alu_flags[3];
      3'b110:  taken = alu_flags[2];
      3'b111:  taken = ~alu_flags[2];
      default: taken = 1'b0;
    endcase
  end

`ifdef MC_CTRL_TRAP_EN
  localparam logic [7:0] TO_LAST = 8'(MEM_TIMEOUT - 1);
  logic [7:0] to_cnt;
  logic [3:0] cause_q;
  logic misaligned;
  assign misaligned = (funct3[1:0] == 2'b10 && addr_lo != 2'b00) ||
                      (funct3[1:0] == 2'b01 && addr_lo[0]);
`endif

  always_comb begin
    state_n     = state;
    pc_write_c  = 1'b0;
    ir_write_c  = 1'b0;
    reg_write_c = 1'b0;
    mem_req_c   = 1'b0;
    mem_we_c    = 1'b0;
    trap_c      = 1'b0;
    trap_code   = 4'd0;
    adr_src     = 1'b0;
    mem_be      = 4'b0000;
    result_src  = 2'b00;
    alu_src_a   = 2'b00;
    alu_src_b   = 2'b00;
    alu_control = ALU_ADD;
    imm_src     = IMM_I;
    case (state)
      S_FETCH: begin
        mem_req_c = 1'b1; mem_be = 4'b1111; alu_src_b = 2'b10; result_src = 2'b10;
        ir_write_c = mem_ready; pc_write_c = mem_ready;
        if (mem_ready) state_n = S_DECODE;
      end
      S_DECODE: begin
        alu_src_a = 2'b01;
        alu_src_b = is_link ? 2'b10 : 2'b01;
        result_src = 2'b10;
        reg_write_c = is_link;
        imm_src = (opcode == OP_JAL) ? IMM_J : (opcode == OP_BRANCH) ? IMM_B :
                  (opcode == OP_AUIPC) ? IMM_U : IMM_I;
        case (opcode)
          OP_R:             state_n = S_EXEC_R;
          OP_I, OP_LUI:     state_n = S_EXEC_I;
          OP_AUIPC:         state_n = S_ALU_WB;
          OP_LOAD, OP_STORE: state_n = S_MEM_ADDR;
          OP_BRANCH:        state_n = S_BRANCH;
          OP_JAL:           state_n = S_JAL;
          OP_JALR:          state_n = S_JALR;
          default: begin
`ifdef MC_CTRL_TRAP_EN
            state_n = S_TRAP;
            trap_code = (opcode == OP_SYSTEM && funct3 == 3'b000) ?
                        (instr_b20 ? 4'd3 : 4'd11) : 4'd2;
`else
            state_n = S_FETCH;
`endif
          end
        endcase
      end
      S_EXEC_R: begin
        alu_src_a = 2'b10; alu_control = alu_dec; state_n = S_ALU_WB;
      end
      S_EXEC_I: begin
        alu_src_a = 2'b10; alu_src_b = 2'b01;
        alu_control = (opcode == OP_LUI) ? 4'd10 : alu_dec;
        imm_src = (opcode == OP_LUI) ? IMM_U : IMM_I;
        state_n = S_ALU_WB;
      end
      S_ALU_WB: begin
        reg_write_c = 1'b1; state_n = S_FETCH;
      end
      S_MEM_ADDR: begin
        alu_src_a = 2'b10; alu_src_b = 2'b01; imm_src = is_store ? IMM_S : IMM_I;
        state_n = is_store ? S_MEM_WRITE : S_MEM_READ;
`ifdef MC_CTRL_TRAP_EN
        if (misaligned) begin
          state_n = S_TRAP;
          trap_code = is_store ? 4'd6 : 4'd4;
        end
`endif
      end
      S_MEM_READ: begin
        adr_src = 1'b1; mem_req_c = 1'b1; mem_be = 4'b1111;
        if (mem_ready) state_n = S_MEM_WB;
      end
      S_MEM_WB: begin
        result_src = 2'b01; reg_write_c = 1'b1; state_n = S_FETCH;
      end
      S_MEM_WRITE: begin
        adr_src = 1'b1; mem_req_c = 1'b1; mem_we_c = 1'b1; mem_be = store_be;
        if (mem_ready) state_n = S_FETCH;
      end
      S_BRANCH: begin
        alu_src_a = 2'b10; alu_control = ALU_SUB; imm_src = IMM_B;
        pc_write_c = taken; state_n = S_FETCH;
      end
      S_JAL: begin
        pc_write_c = 1'b1; state_n = S_FETCH;
      end
      S_JALR: begin
        alu_src_a = 2'b10; alu_src_b = 2'b01; result_src = 2'b10;
        pc_write_c = 1'b1; state_n = S_FETCH;
      end
      default: begin
        trap_c = 1'b1; state_n = S_FETCH;
      end
    endcase
`ifdef MC_CTRL_TRAP_EN
    // ready on the final allowed wait cycle still completes the access
    if (mem_req_c && !mem_ready && to_cnt == TO_LAST) begin
      state_n = S_TRAP;
      trap_code = (state == S_FETCH) ? 4'd1 : (state == S_MEM_READ) ? 4'd5 : 4'd7;
    end
`endif
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state     <= S_FETCH;
      instret_q <= '0;
    end else begin
      state <= state_n;
      if (state_n == S_FETCH && state != S_FETCH && state != S_TRAP)
        instret_q <= instret_q + INSTRET_W'(1);
    end
  end

  // strobes are forced low while reset is held so an aborted access never writes
  assign pc_write  = pc_write_c  & resetn;
  assign ir_write  = ir_write_c  & resetn;
  assign reg_write = reg_write_c & resetn;
  assign mem_req   = mem_req_c   & resetn;
  assign mem_we    = mem_we_c    & resetn;
  assign instret   = instret_q;

`ifdef MC_CTRL_TRAP_EN
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      to_cnt  <= 8'd0;
      cause_q <= 4'd0;
    end else begin
      if (state_n != state || mem_ready) to_cnt <= 8'd0;
      else if (mem_req_c) to_cnt <= to_cnt + 8'd1;
      if (state_n == S_TRAP) cause_q <= trap_code;
    end
  end
  assign trap       = trap_c & resetn;
  assign trap_cause = cause_q;
  logic unused_ok;
  assign unused_ok = &{1'b0, alu_flags[1:0]};
`else
  localparam int unused_timeout = MEM_TIMEOUT;
  assign trap       = 1'b0;
  assign trap_cause = 4'd0;
  logic unused_ok;
  assign unused_ok = &{1'b0, alu_flags[1:0], instr_b20, trap_c, trap_code};
`endif
endmodule

// File: tb/tb_mc_control_hs.sv
// tb/tb_mc_control_hs.sv - randomized instruction-level model check of mc_control_hs
module tb_mc_control_hs;
  localparam int TO = 4;
  localparam int IW = 4;
`ifdef MC_CTRL_TRAP_EN
  localparam bit TRAP_EN = 1'b1;
`else
  localparam bit TRAP_EN = 1'b0;
`endif
  localparam logic [6:0] OP_R = 7'b0110011, OP_I = 7'b0010011, OP_LUI = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111, OP_LOAD = 7'b0000011, OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_BR = 7'b1100011, OP_JAL = 7'b1101111, OP_JALR = 7'b1100111;
  localparam logic [6:0] OP_SYS = 7'b1110011;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  logic [6:0] opcode = '0, funct7 = '0;
  logic [2:0] funct3 = '0;
  logic instr_b20 = 1'b0, mem_ready = 1'b0;
  logic [4:0] alu_flags = '0;
  logic [1:0] addr_lo = '0;
  logic pc_write, ir_write, reg_write, adr_src, mem_req, mem_we, trap;
  logic [3:0] mem_be, alu_control, trap_cause;
  logic [1:0] result_src, alu_src_a, alu_src_b;
  logic [2:0] imm_src;
  logic [IW-1:0] instret;

  mc_control_hs #(.MEM_TIMEOUT(TO), .INSTRET_W(IW)) dut (
    .clk(clk), .resetn(resetn), .opcode(opcode), .funct3(funct3), .funct7(funct7),
    .instr_b20(instr_b20), .alu_flags(alu_flags), .addr_lo(addr_lo), .mem_ready(mem_ready),
    .pc_write(pc_write), .ir_write(ir_write), .reg_write(reg_write), .adr_src(adr_src),
    .mem_req(mem_req), .mem_we(mem_we), .mem_be(mem_be), .result_src(result_src),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_control(alu_control),
    .imm_src(imm_src), .trap(trap), .trap_cause(trap_cause), .instret(instret)
  );

  always #5 clk = ~clk;

  int vectors = 0, miscompares = 0, cyc = 0, m_instret = 0, m_cause = 0;
  bit chk_on = 1'b0;
  logic e_pcw, e_irw, e_rw, e_req, e_we, e_trap, e_adr;
  logic [3:0] e_be, e_alu;
  logic [1:0] e_res, e_sa, e_sb;
  logic [2:0] e_imm;
  bit c_alu, c_src, c_res, c_imm;

  task automatic chk(input string nm, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (chk_on) begin
      chk("pc_write", pc_write, e_pcw);
      chk("ir_write", ir_write, e_irw);
      chk("reg_write", reg_write, e_rw);
      chk("mem_req", mem_req, e_req);
      chk("mem_we", mem_we, e_we);
      chk("trap", trap, e_trap);
      chk("trap_cause", trap_cause, m_cause);
      chk("instret", instret, m_instret % (1 << IW));
      if (e_req) begin
        chk("mem_be", mem_be, e_be);
        chk("adr_src", adr_src, e_adr);
      end
      if (c_alu) chk("alu_control", alu_control, e_alu);
      if (c_src) begin
        chk("alu_src_a", alu_src_a, e_sa);
        chk("alu_src_b", alu_src_b, e_sb);
      end
      if (c_res) chk("result_src", result_src, e_res);
      if (c_imm) chk("imm_src", imm_src, e_imm);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // non-memory cycles get a random ready level, which must be ignored
  task automatic clr_exp();
    {e_pcw, e_irw, e_rw, e_req, e_we, e_trap, e_adr} = '0;
    {c_alu, c_src, c_res, c_imm} = '0;
    mem_ready = 1'($urandom_range(0, 1));
  endtask

  function automatic logic [3:0] alu_model(input logic [2:0] f3, input logic [6:0] f7, input bit r);
    logic [3:0] t [8];
    t = '{4'd3, 4'd7, 4'd5, 4'd6, 4'd2, 4'd8, 4'd1, 4'd0};
    if (f3 == 3'd0 && r && f7 == 7'h20) return 4'd4;
    if (f3 == 3'd5 && f7 == 7'h20) return 4'd9;
    return t[f3];
  endfunction

  function automatic logic [3:0] be_model(input logic [2:0] f3, input logic [1:0] a);
    int sz = 1 << f3[1:0];
    if (sz == 1) return 4'(1 << a);
    if (sz == 2) return (a >= 2) ? 4'b1100 : 4'b0011;
    return 4'b1111;
  endfunction

  function automatic bit taken_model(input logic [2:0] f3, input logic [4:0] fl);
    bit z = fl[4], lt = fl[3], ltu = fl[2];
    case (f3)
      3'd0: return z;
      3'd1: return !z;
      3'd4: return lt;
      3'd5: return !lt;
      3'd6: return ltu;
      3'd7: return !ltu;
      default: return 1'b0;
    endcase
  endfunction

  // kind: 0 fetch, 1 load, 2 store; one call covers every cycle of the access
  task automatic mem_phase(input int kind, input int waits, input logic [3:0] be, output bit fault);
    fault = 1'b0;
    for (int i = 0; i < 64; i++) begin
      clr_exp();
      mem_ready = (i >= waits);
      e_req = 1'b1; e_be = be; e_adr = (kind != 0); e_we = (kind == 2);
      if (kind == 0) begin
        e_irw = mem_ready; e_pcw = mem_ready;
        c_alu = 1; e_alu = 4'd3; c_src = 1; e_sa = 2'd0; e_sb = 2'd2;
        c_res = mem_ready; e_res = 2'd2;
      end
      tick();
      if (i >= waits) break;
      if (TRAP_EN && i + 1 == TO) begin fault = 1'b1; break; end
    end
  endtask

  task automatic decode_cycle(input logic [6:0] op);
    clr_exp();
    c_alu = 1; e_alu = 4'd3; c_src = 1; e_sa = 2'd1; e_sb = 2'd1;
    if (op == OP_JAL || op == OP_JALR) begin
      e_rw = 1'b1; e_sb = 2'd2; c_res = 1; e_res = 2'd2;
    end
    if (op == OP_JAL) begin c_imm = 1; e_imm = 3'd4; end
    if (op == OP_BR) begin c_imm = 1; e_imm = 3'd1; end
    if (op == OP_AUIPC) begin c_imm = 1; e_imm = 3'd3; end
    tick();
  endtask

  task automatic addr_cycle(input bit st);
    clr_exp();
    c_alu = 1; e_alu = 4'd3; c_src = 1; e_sa = 2'd2; e_sb = 2'd1;
    c_imm = 1; e_imm = st ? 3'd2 : 3'd0;
    tick();
  endtask

  task automatic wb_cycle(input logic [1:0] res);
    clr_exp(); e_rw = 1'b1; c_res = 1; e_res = res;
    tick();
  endtask

  task automatic trap_cycle();
    clr_exp(); e_trap = 1'b1;
    tick();
  endtask

  task automatic retire();
    m_instret++;
  endtask

  task automatic run_instr(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                           input logic b20, input logic [4:0] fl, input logic [1:0] alo,
                           input int wf, input int wm);
    bit fault, mis, st;
    opcode = op; funct3 = f3; funct7 = f7; instr_b20 = b20; alu_flags = fl; addr_lo = alo;
    mem_phase(0, wf, 4'hf, fault);
    if (fault) begin m_cause = 1; trap_cycle(); return; end
    decode_cycle(op);
    case (op)
      OP_R, OP_I, OP_LUI: begin
        clr_exp();
        c_alu = 1; c_src = 1; e_sa = 2'd2; e_sb = (op == OP_R) ? 2'd0 : 2'd1;
        e_alu = (op == OP_LUI) ? 4'd10 : alu_model(f3, f7, op == OP_R);
        if (op != OP_R) begin c_imm = 1; e_imm = (op == OP_LUI) ? 3'd3 : 3'd0; end
        tick();
        wb_cycle(2'd0); retire();
      end
      OP_AUIPC: begin wb_cycle(2'd0); retire(); end
      OP_LOAD, OP_STORE: begin
        st = (op == OP_STORE);
        addr_cycle(st);
        mis = (f3[1:0] == 2'd2 && alo != 2'd0) || (f3[1:0] == 2'd1 && alo[0]);
        if (TRAP_EN && mis) begin m_cause = st ? 6 : 4; trap_cycle(); return; end
        mem_phase(st ? 2 : 1, wm, st ? be_model(f3, alo) : 4'hf, fault);
        if (fault) begin m_cause = st ? 7 : 5; trap_cycle(); return; end
        if (!st) wb_cycle(2'd1);
        retire();
      end
      OP_BR: begin
        clr_exp();
        c_alu = 1; e_alu = 4'd4; c_src = 1; e_sa = 2'd2; e_sb = 2'd0;
        e_pcw = taken_model(f3, fl);
        tick(); retire();
      end
      OP_JAL: begin
        clr_exp(); e_pcw = 1'b1; c_res = 1; e_res = 2'd0;
        tick(); retire();
      end
      OP_JALR: begin
        clr_exp(); e_pcw = 1'b1; c_alu = 1; e_alu = 4'd3; c_src = 1; e_sa = 2'd2; e_sb = 2'd1;
        c_imm = 1; e_imm = 3'd0; c_res = 1; e_res = 2'd2;
        tick(); retire();
      end
      default: begin
        if (TRAP_EN) begin
          m_cause = (op == OP_SYS && f3 == 3'd0) ? (b20 ? 3 : 11) : 2;
          trap_cycle();
        end else retire();
      end
    endcase
  endtask

  initial begin
    int c0;
    bit fault;
    logic [6:0] op, f7;
    logic [2:0] f3;
    logic [6:0] ill [3];
    logic [2:0] ldf [5];
    ill = '{7'b0001111, 7'b1111111, 7'b0000000};
    ldf = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
    clr_exp();
    chk_on = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_instret", instret, 0);
    chk("rst_mem_req", mem_req, 0);
    resetn = 1'b1;

    c0 = cyc;
    run_instr(OP_R, 3'd0, 7'h00, 1'b0, 5'd0, 2'd0, 0, 0);
    chk("add_cycles", cyc - c0, 4);
    chk("add_instret", instret, 1);
    for (int i = 0; i < 16; i++) run_instr(OP_R, 3'd0, 7'h00, 1'b0, 5'd0, 2'd0, 0, 0);
    chk("wrap_instret", instret, 1);

    c0 = cyc;
    run_instr(OP_STORE, 3'd1, 7'h00, 1'b0, 5'd0, 2'd2, 3, 3);
    chk("sh_cycles", cyc - c0, 10);
    c0 = cyc;
    run_instr(OP_BR, 3'd1, 7'h00, 1'b0, 5'b10000, 2'd0, 0, 0);
    run_instr(OP_BR, 3'd6, 7'h00, 1'b0, 5'b00100, 2'd0, 0, 0);
    chk("branch_cycles", cyc - c0, 6);
    chk("branch_instret", instret, 4);

    c0 = cyc;
    run_instr(OP_LOAD, 3'd2, 7'h00, 1'b0, 5'd0, 2'd1, 0, 0);
`ifdef MC_CTRL_TRAP_EN
    chk("lw_mis_cycles", cyc - c0, 4);
    chk("lw_mis_cause", trap_cause, 4);
    chk("lw_mis_instret", instret, 4);
    c0 = cyc;
    run_instr(OP_R, 3'd0, 7'h00, 1'b0, 5'd0, 2'd0, 10, 0);
    chk("fetch_to_cycles", cyc - c0, 5);
    chk("fetch_to_cause", trap_cause, 1);
    c0 = cyc;
    run_instr(OP_R, 3'd0, 7'h00, 1'b0, 5'd0, 2'd0, 3, 0);
    chk("fetch_edge_cycles", cyc - c0, 7);
    chk("fetch_edge_instret", instret, 5);
`else
    chk("lw_mis_cycles", cyc - c0, 5);
    chk("lw_mis_instret", instret, 5);
    c0 = cyc;
    run_instr(OP_R, 3'd0, 7'h00, 1'b0, 5'd0, 2'd0, 3, 0);
    chk("fetch_wait_cycles", cyc - c0, 7);
    chk("fetch_wait_instret", instret, 6);
`endif

    for (int n = 0; n < 400; n++) begin
      int k = $urandom_range(0, 11);
      f3 = 3'($urandom_range(0, 7));
      f7 = ($urandom_range(0, 3) == 0) ? 7'($urandom) : ($urandom_range(0, 1) ? 7'h20 : 7'h00);
      case (k)
        0, 1:  op = OP_R;
        2:     op = OP_I;
        3:     op = OP_LUI;
        4:     op = OP_AUIPC;
        5:     begin op = OP_LOAD; f3 = ldf[$urandom_range(0, 4)]; end
        6:     begin op = OP_STORE; f3 = 3'($urandom_range(0, 2)); end
        7:     op = OP_BR;
        8:     op = OP_JAL;
        9:     op = OP_JALR;
        10:    begin op = OP_SYS; f3 = 3'd0; end
        default: op = ill[$urandom_range(0, 2)];
      endcase
      run_instr(op, f3, f7, 1'($urandom), 5'($urandom), 2'($urandom),
                ($urandom_range(0, 5) == 0) ? $urandom_range(1, 6) : 0,
                ($urandom_range(0, 3) == 0) ? $urandom_range(1, 6) : 0);
    end

    opcode = OP_STORE; funct3 = 3'd1; addr_lo = 2'd0;
    mem_phase(0, 0, 4'hf, fault);
    decode_cycle(OP_STORE);
    addr_cycle(1'b1);
    clr_exp();
    mem_ready = 1'b0; e_req = 1'b1; e_we = 1'b1; e_adr = 1'b1; e_be = 4'b0011;
    tick();
    clr_exp();
    mem_ready = 1'b0; resetn = 1'b0; m_instret = 0; m_cause = 0;
    #1;
    chk("rst_mid_mem_we", mem_we, 0);
    chk("rst_mid_instret", instret, 0);
    tick();
    resetn = 1'b1;
    c0 = cyc;
    run_instr(OP_R, 3'd0, 7'h00, 1'b0, 5'd0, 2'd0, 0, 0);
    chk("post_rst_cycles", cyc - c0, 4);
    chk("post_rst_instret", instret, 1);

    chk_on = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/mc_control_hs.md
# mc_control_hs

Multicycle RV32I control unit with a variable-latency memory handshake, sub-word byte-enable generation, bus-timeout detection and a retired-instruction counter. It sits between the instruction register/decoder fields and the datapath muxes, ALU, register file and memory port of the multicycle core. It generalises the fixed-latency control FSM to memories with arbitrary wait states and adds trap reporting.

## Interface
- MEM_TIMEOUT, 16: cycles `mem_req` may stay high without `mem_ready` before an access fault; range 1..255.
- INSTRET_W, 32: width of the retired-instruction counter.
- clk  in  1  clock
- resetn  in  1  reset, asynchronous, active-low
- opcode  in  7  instruction[6:0]
- funct3  in  3  instruction[14:12]
- funct7  in  7  instruction[31:25]
- instr_b20  in  1  instruction[20]; for SYSTEM, 0 = ECALL, 1 = EBREAK
- alu_flags  in  5  {zero, lt, ltu, sign, overflow}
- addr_lo  in  2  ALU result[1:0]; the memory address low bits
- mem_ready  in  1  memory completes the current access this cycle
- pc_write, ir_write, reg_write  out  1  datapath write strobes
- adr_src  out  1  0 = PC, 1 = ALU result
- mem_req  out  1  memory access request
- mem_we  out  1  write request; valid only with `mem_req`
- mem_be  out  4  byte enables
- result_src, alu_src_a, alu_src_b  out  2  mux selects; encoding identical to the current control unit
- alu_control  out  4  ALU op: AND 0, OR 1, XOR 2, ADD 3, SUB 4, SLT 5, SLTU 6, SLL 7, SRL 8, SRA 9, LUI 10
- imm_src  out  3  I 0, B 1, S 2, U 3, J 4
- trap  out  1  one-cycle trap pulse
- trap_cause  out  4  RISC-V mcause code; held until the next trap
- instret  out  INSTRET_W  retired-instruction count

## Operation
- States: FETCH, DECODE, EXEC_R, EXEC_I, ALU_WB, MEM_ADDR, MEM_READ, MEM_WB, MEM_WRITE, BRANCH, JAL, JALR, TRAP.
- FETCH:
  - Drives `mem_req=1`, `adr_src=0`, `mem_be=1111`, and PC+4 through the ALU with ADD.
  - `ir_write` and `pc_write` follow `mem_ready`. Goes to DECODE on `mem_ready`; otherwise stays.
- DECODE:
  - For JAL/JALR, writes the link value PC+4 (`reg_write=1`). Otherwise computes PC+imm.
  - Dispatch: R → EXEC_R; I/LUI → EXEC_I; AUIPC → ALU_WB; LOAD/STORE → MEM_ADDR; BRANCH → BRANCH; JAL → JAL; JALR → JALR; SYSTEM/other → TRAP.
- EXEC_R/EXEC_I: full funct3/funct7 ALU decode; SUB/SRA when funct7=0100000. Both go to ALU_WB. ALU_WB goes to FETCH.
- MEM_ADDR: computes rs1+imm and checks alignment.
  - Misaligned when word access has `addr_lo`≠00, or halfword access has `addr_lo[0]`=1.
  - Misaligned → TRAP, cause 4 (load) or 6 (store). Otherwise LOAD → MEM_READ, STORE → MEM_WRITE.
- MEM_READ/MEM_WRITE: `adr_src=1`, `mem_req=1`; MEM_WRITE also sets `mem_we=1`.
  - Byte enables: SB → 1<<addr_lo; SH → 0011 if addr_lo[1]=0, else 1100; SW and all loads → 1111.
  - On `mem_ready`: MEM_READ → MEM_WB; MEM_WRITE → FETCH.
- MEM_WB: `result_src=01`, `reg_write=1`, then FETCH.
- BRANCH: SUB. `pc_write` = zero / ~zero / lt / ~lt / ltu / ~ltu for BEQ/BNE/BLT/BGE/BLTU/BGEU; undefined funct3 gives `pc_write=0`. Then FETCH.
- JAL (PC+imm) and JALR (rs1+imm): `pc_write=1`, then FETCH.
- TRAP: `trap=1` for one cycle and `trap_cause` latched, then FETCH.
  - Causes: illegal opcode 2, EBREAK 3, ECALL 11.
  - Timeout: fetch 1, load 5, store 7.
- Timeout counter:
  - Increments each cycle `mem_req=1 && mem_ready=0`. Clears on `mem_ready` and on any state change.
  - When it reaches MEM_TIMEOUT, goes to TRAP with the access-fault cause.
- `instret`:
  - Increments on every transition into FETCH from any state except TRAP, and on a not-taken branch.
  - Wraps modulo 2^INSTRET_W.

## Timing
- Reset:
  - State = FETCH, `instret`=0, `trap_cause`=0, timeout counter = 0.
  - While `resetn`=0, all strobes (`pc_write`, `ir_write`, `reg_write`, `mem_req`, `mem_we`, `trap`) are 0.
  - Reset asserted mid-access aborts the access with no write strobes.
- All outputs are combinational from state and inputs; state and counters update on the `clk` rising edge.
- Handshake: once raised, `mem_req`, `mem_we`, `mem_be` and `adr_src` stay stable until the cycle `mem_ready`=1. The access completes at the end of that cycle.
- Latency with zero wait states (`mem_ready` tied 1):

  | Instruction | Cycles |
  |---|---|
  | R/I/LUI | 4 |
  | AUIPC | 3 |
  | load | 5 |
  | store | 4 |
  | branch | 3 |
  | JAL/JALR | 3 |
  | trap | 3 |

  Each memory wait cycle adds one cycle.
- `mem_ready` high on the same cycle the timeout is reached: ready wins and no trap is taken.

## Configuration
- `MC_CTRL_TRAP_EN` defined:
  - TRAP state, the timeout counter, the misalignment check and the `trap`/`trap_cause` outputs are active.
- Undefined:
  - Illegal/SYSTEM instructions go DECODE → FETCH as NOPs and count in `instret`.
  - Misaligned accesses proceed using `mem_be` computed from `addr_lo`.
  - Memory waits indefinitely.
  - `trap` and `trap_cause` tie to 0.

## Test plan
- ADD with `mem_ready`=1 → FETCH, DECODE, EXEC_R, ALU_WB; `reg_write` in cycle 4 with `alu_control`=3; `instret` 0→1.
- SH with `addr_lo`=10 and FETCH/MEM_WRITE `mem_ready` delayed 3 cycles each → `mem_be`=1100, `mem_we` held 4 cycles, 10 cycles total.
- LW with `addr_lo`=01 (trap enabled) → `trap` pulse, `trap_cause`=4, no `mem_req` in MEM_READ, `instret` unchanged.
- FETCH with `mem_ready` stuck 0, MEM_TIMEOUT=4 → TRAP after 4 wait cycles, `trap_cause`=1; ready arriving exactly on cycle 4 → no trap.
- BNE with zero=1 → `pc_write`=0; BLTU with ltu=1 → `pc_write`=1; both return to FETCH.
- INSTRET_W=4 with 17 ADDs → `instret`=1 (wrap); `resetn` pulsed low mid-MEM_WRITE → `mem_we`=0 immediately, FETCH next, `instret`=0.
